// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM request arbiter.
package psram_pkg;

    typedef enum logic [2:0] {
        StDelay,
        StQpiEnter,
        StIdle,
        StIssue,
        StWait,
        StRelease
    } state_e;

    localparam logic [7:0] CMD_QUAD_READ  = 8'hEB;
    localparam logic [7:0] CMD_QUAD_WRITE = 8'h38;
    localparam logic [7:0] CMD_QPI_ENTER  = 8'h35;

    localparam logic P_FETCH = 1'b0;
    localparam logic P_DATA  = 1'b1;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic        we;
    } txn_t;

    // Byte counts outside 1..4 are treated as a full word.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return ((size == 3'd0) || (size > 3'd4)) ? 3'd4 : size;
    endfunction

    // Zero the bytes above the transferred count.
    function automatic logic [31:0] mask_rdata(input logic [31:0] data, input logic [2:0] size);
        logic [31:0] res;
        case (size)
            3'd1:    res = {24'h0, data[7:0]};
            3'd2:    res = {16'h0, data[15:0]};
            3'd3:    res = {8'h0, data[23:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/psram_req_arbiter_if.sv
// Controller-side bus of the PSRAM request arbiter.
interface psram_req_arbiter_if;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  mem_size;
    logic        mem_start;
    logic        mem_done;
    logic [3:0]  mem_wait_states;
    logic [7:0]  mem_cmd;
    logic        mem_rd_wr;
    logic        mem_qspi;
    logic        mem_qpi;
    logic        mem_short_cmd;

    modport master (
        output mem_addr, mem_wdata, mem_size, mem_start, mem_wait_states, mem_cmd,
               mem_rd_wr, mem_qspi, mem_qpi, mem_short_cmd,
        input  mem_rdata, mem_done
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_size, mem_start, mem_wait_states, mem_cmd,
               mem_rd_wr, mem_qspi, mem_qpi, mem_short_cmd,
        output mem_rdata, mem_done
    );
endinterface

// File: rtl/psram_rr_arb2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
module psram_rr_arb2
    import psram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    input  logic gnt_en_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    logic last_q, last_d;

    // Grant the lone requester, or on a tie the port not served last.
    always_comb begin
        gnt_valid_o = gnt_en_i & (req0_i | req1_i);
        if (req0_i && req1_i) begin
            gnt_id_o = ~last_q;
        end else begin
            gnt_id_o = req1_i ? P_DATA : P_FETCH;
        end
        last_d = gnt_valid_o ? gnt_id_o : last_q;
    end

    // Pointer starts as if port 1 was served last so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= P_DATA;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/psram_req_arbiter.sv
// Arbitrates fetch and data requesters onto one PSRAM controller.
// Optional QPI-entry sequence after power-up: define PSRAM_ARB_QPI_INIT_EN.
module psram_req_arbiter
    import psram_pkg::*;
#(
    parameter int unsigned INIT_DELAY = 16,
    parameter logic [3:0]  RD_WAIT    = 4'd6,
    parameter logic [7:0]  RD_CMD     = CMD_QUAD_READ,
    parameter logic [7:0]  WR_CMD     = CMD_QUAD_WRITE
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_done,
    input  logic                       p0_req,
    input  logic [23:0]                p0_addr,
    output logic [31:0]                p0_rdata,
    output logic                       p0_ack,
    input  logic                       p1_req,
    input  logic                       p1_we,
    input  logic [23:0]                p1_addr,
    input  logic [31:0]                p1_wdata,
    input  logic [2:0]                 p1_size,
    output logic [31:0]                p1_rdata,
    output logic                       p1_ack,
    psram_req_arbiter_if.master        mem
);

    localparam int unsigned CntW = (INIT_DELAY < 2) ? 1 : $clog2(INIT_DELAY + 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    txn_t            txn_q, txn_d;
    logic            port_q, port_d;
    logic            init_done_q, init_done_d;
    logic [31:0]     p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic            p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
    logic            gnt_valid, gnt_id, txn_busy;
`ifdef PSRAM_ARB_QPI_INIT_EN
    logic [1:0]      qpi_ph_q, qpi_ph_d;
`endif

    psram_rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req0_i     (p0_req),
        .req1_i     (p1_req),
        .gnt_en_i   (state_q == StIdle),
        .gnt_valid_o(gnt_valid),
        .gnt_id_o   (gnt_id)
    );

    // Next-state logic: power-up delay, optional QPI entry, grant and handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        txn_d       = txn_q;
        port_d      = port_q;
        init_done_d = init_done_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
`ifdef PSRAM_ARB_QPI_INIT_EN
        qpi_ph_d    = qpi_ph_q;
`endif
        case (state_q)
            StDelay: begin
                if (cnt_q != CntW'(INIT_DELAY)) begin
                    cnt_d = cnt_q + CntW'(1);
                end else if (!mem.mem_done) begin
`ifdef PSRAM_ARB_QPI_INIT_EN
                    state_d  = StQpiEnter;
                    qpi_ph_d = 2'd0;
`else
                    state_d     = StIdle;
                    init_done_d = 1'b1;
`endif
                end
            end
`ifdef PSRAM_ARB_QPI_INIT_EN
            // Phase 0 pulses start, 1 waits for done, 2 waits for done to drop.
            StQpiEnter: begin
                case (qpi_ph_q)
                    2'd0: qpi_ph_d = 2'd1;
                    2'd1: if (mem.mem_done) qpi_ph_d = 2'd2;
                    default: begin
                        if (!mem.mem_done) begin
                            state_d     = StIdle;
                            init_done_d = 1'b1;
                        end
                    end
                endcase
            end
`endif
            StIdle: begin
                if (gnt_valid) begin
                    port_d = gnt_id;
                    if (gnt_id == P_DATA) begin
                        txn_d.addr  = p1_addr;
                        txn_d.wdata = p1_wdata;
                        txn_d.size  = clamp_size(p1_size);
                        txn_d.we    = p1_we;
                    end else begin
                        txn_d.addr  = p0_addr;
                        txn_d.wdata = 32'h0;
                        txn_d.size  = 3'd4;
                        txn_d.we    = 1'b0;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (mem.mem_done) begin
                    if (port_q == P_FETCH) begin
                        p0_ack_d   = 1'b1;
                        p0_rdata_d = mask_rdata(mem.mem_rdata, txn_q.size);
                    end else begin
                        p1_ack_d = 1'b1;
                        if (!txn_q.we) begin
                            p1_rdata_d = mask_rdata(mem.mem_rdata, txn_q.size);
                        end
                    end
                    state_d = StRelease;
                end
            end
            // Done is held for a few cycles; wait it out so it is counted once.
            StRelease: if (!mem.mem_done) state_d = StIdle;
            default: state_d = StDelay;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StDelay;
            cnt_q       <= '0;
            txn_q       <= '0;
            port_q      <= P_FETCH;
            init_done_q <= 1'b0;
            p0_rdata_q  <= 32'h0;
            p1_rdata_q  <= 32'h0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
`ifdef PSRAM_ARB_QPI_INIT_EN
            qpi_ph_q    <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            txn_q       <= txn_d;
            port_q      <= port_d;
            init_done_q <= init_done_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_ack_q    <= p0_ack_d;
            p1_ack_q    <= p1_ack_d;
`ifdef PSRAM_ARB_QPI_INIT_EN
            qpi_ph_q    <= qpi_ph_d;
`endif
        end
    end

    // Controller field mapping, driven only while a transaction is in flight.
    always_comb begin
        txn_busy            = (state_q == StIssue) || (state_q == StWait) ||
                              (state_q == StRelease);
        mem.mem_addr        = txn_q.addr;
        mem.mem_wdata       = txn_q.wdata;
        mem.mem_size        = txn_q.size;
        mem.mem_start       = (state_q == StIssue);
        mem.mem_cmd         = 8'h0;
        mem.mem_rd_wr       = 1'b0;
        mem.mem_wait_states = 4'h0;
        mem.mem_short_cmd   = 1'b0;
        if (txn_busy) begin
            mem.mem_cmd         = txn_q.we ? WR_CMD : RD_CMD;
            mem.mem_rd_wr       = ~txn_q.we;
            mem.mem_wait_states = txn_q.we ? 4'h0 : RD_WAIT;
        end
`ifdef PSRAM_ARB_QPI_INIT_EN
        if (state_q == StQpiEnter) begin
            mem.mem_start     = (qpi_ph_q == 2'd0);
            mem.mem_cmd       = CMD_QPI_ENTER;
            mem.mem_short_cmd = 1'b1;
        end
        mem.mem_qspi = 1'b0;
        mem.mem_qpi  = init_done_q;
`else
        mem.mem_qspi = init_done_q;
        mem.mem_qpi  = 1'b0;
`endif
    end

    assign init_done = init_done_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;

endmodule

// File: tb/tb_psram_req_arbiter.sv
// Directed testbench for psram_req_arbiter with a simple controller model.
module tb_psram_req_arbiter;
    import psram_pkg::*;

    localparam int unsigned INIT_DELAY = 16;
`ifdef PSRAM_ARB_QPI_INIT_EN
    localparam int  QPI_STARTS = 1;
    localparam logic EXP_QSPI  = 1'b0;
    localparam logic EXP_QPI   = 1'b1;
`else
    localparam int  QPI_STARTS = 0;
    localparam logic EXP_QSPI  = 1'b1;
    localparam logic EXP_QPI   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done;
    logic        p0_req = 1'b0;
    logic [23:0] p0_addr = 24'h0;
    logic [31:0] p0_rdata;
    logic        p0_ack;
    logic        p1_req = 1'b0;
    logic        p1_we = 1'b0;
    logic [23:0] p1_addr = 24'h0;
    logic [31:0] p1_wdata = 32'h0;
    logic [2:0]  p1_size = 3'd4;
    logic [31:0] p1_rdata;
    logic        p1_ack;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psram_req_arbiter_if mem_if ();

    psram_req_arbiter #(
        .INIT_DELAY(INIT_DELAY),
        .RD_WAIT   (4'd6),
        .RD_CMD    (8'hEB),
        .WR_CMD    (8'h38)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .init_done(init_done),
        .p0_req   (p0_req),
        .p0_addr  (p0_addr),
        .p0_rdata (p0_rdata),
        .p0_ack   (p0_ack),
        .p1_req   (p1_req),
        .p1_we    (p1_we),
        .p1_addr  (p1_addr),
        .p1_wdata (p1_wdata),
        .p1_size  (p1_size),
        .p1_rdata (p1_rdata),
        .p1_ack   (p1_ack),
        .mem      (mem_if)
    );

    // Controller model: done rises 3 cycles after start, held done_len cycles.
    typedef struct packed {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic        rd_wr;
        logic [3:0]  ws;
        logic        short_cmd;
        logic        qspi;
        logic        qpi;
    } start_rec_t;

    start_rec_t  log_q[$];
    start_rec_t  rec;
    int          m_wait = 0;
    int          m_hold = 0;
    int          done_len = 2;
    int          ack0_cnt = 0;
    int          ack1_cnt = 0;
    int          bad_start = 0;
    logic [31:0] model_data = 32'hDEADBEEF;

    assign mem_if.mem_done  = (m_hold > 0);
    assign mem_if.mem_rdata = model_data;

    always @(posedge clk) begin
        if (mem_if.mem_start) begin
            rec.cmd       = mem_if.mem_cmd;
            rec.addr      = mem_if.mem_addr;
            rec.wdata     = mem_if.mem_wdata;
            rec.size      = mem_if.mem_size;
            rec.rd_wr     = mem_if.mem_rd_wr;
            rec.ws        = mem_if.mem_wait_states;
            rec.short_cmd = mem_if.mem_short_cmd;
            rec.qspi      = mem_if.mem_qspi;
            rec.qpi       = mem_if.mem_qpi;
            log_q.push_back(rec);
            if (mem_if.mem_done) bad_start <= bad_start + 1;
            m_wait <= 3;
        end else if (m_wait > 0) begin
            if (m_wait == 1) m_hold <= done_len;
            m_wait <= m_wait - 1;
        end else if (m_hold > 0) begin
            m_hold <= m_hold - 1;
        end
        if (p0_ack) ack0_cnt <= ack0_cnt + 1;
        if (p1_ack) ack1_cnt <= ack1_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bit got;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (init_done) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL init_timeout: init_done=%0b required 1", init_done);
        end
    endtask

    task automatic run_p1(input logic we, input logic [23:0] a, input logic [31:0] wd,
                          input logic [2:0] sz);
        bit got;
        p1_we    = we;
        p1_addr  = a;
        p1_wdata = wd;
        p1_size  = sz;
        p1_req   = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (p1_ack) begin
                got = 1'b1;
                break;
            end
        end
        p1_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL p1_ack_timeout: ack not seen, required within 80 cycles");
        end
    endtask

    task automatic test_reset();
        bit got;
        int a0;
        p0_addr    = 24'h000100;
        p0_req     = 1'b1;
        model_data = 32'hDEADBEEF;
        rst        = 1'b1;
        tick();
        tick();
        checks++;
        if ({init_done, p0_ack, p1_ack, mem_if.mem_start} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000",
                     {init_done, p0_ack, p1_ack, mem_if.mem_start});
        end
        checks++;
        if ({p0_rdata, p1_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h required 0", {p0_rdata, p1_rdata});
        end
        checks++;
        if ({mem_if.mem_cmd, mem_if.mem_qspi, mem_if.mem_qpi, mem_if.mem_short_cmd} !== 11'h0)
        begin
            errors++;
            $display("FAIL reset_mode: cmd=%h qspi=%b qpi=%b short=%b required 0",
                     mem_if.mem_cmd, mem_if.mem_qspi, mem_if.mem_qpi, mem_if.mem_short_cmd);
        end
        a0  = ack0_cnt;
        rst = 1'b0;
        repeat (INIT_DELAY) tick();
        checks++;
        if (log_q.size() != 0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL init_delay: starts=%0d init_done=%b required 0 and 0",
                     log_q.size(), init_done);
        end
        got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (p0_ack) begin
                got = 1'b1;
                break;
            end
        end
        p0_req = 1'b0;
        checks++;
        if (!got || p0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL p0_rdata: got %h ack=%b required DEADBEEF", p0_rdata, got);
        end
        checks++;
        if (log_q.size() != QPI_STARTS + 1) begin
            errors++;
            $display("FAIL first_starts: got %0d required %0d", log_q.size(), QPI_STARTS + 1);
        end else begin
            rec = log_q[log_q.size() - 1];
            checks++;
            if (rec.cmd !== 8'hEB || rec.rd_wr !== 1'b1 || rec.ws !== 4'd6 ||
                rec.size !== 3'd4 || rec.addr !== 24'h000100) begin
                errors++;
                $display("FAIL p0_fields: cmd=%h rw=%b ws=%0d size=%0d addr=%h required EB 1 6 4 000100",
                         rec.cmd, rec.rd_wr, rec.ws, rec.size, rec.addr);
            end
            checks++;
            if (rec.qspi !== EXP_QSPI || rec.qpi !== EXP_QPI || rec.short_cmd !== 1'b0) begin
                errors++;
                $display("FAIL p0_mode: qspi=%b qpi=%b short=%b required %b %b 0",
                         rec.qspi, rec.qpi, rec.short_cmd, EXP_QSPI, EXP_QPI);
            end
`ifdef PSRAM_ARB_QPI_INIT_EN
            checks++;
            if (log_q[0].cmd !== 8'h35 || log_q[0].short_cmd !== 1'b1 || log_q[0].qpi !== 1'b0 ||
                log_q[0].qspi !== 1'b0) begin
                errors++;
                $display("FAIL qpi_enter: cmd=%h short=%b qpi=%b qspi=%b required 35 1 0 0",
                         log_q[0].cmd, log_q[0].short_cmd, log_q[0].qpi, log_q[0].qspi);
            end
`endif
        end
        tick();
        checks++;
        if (p0_ack !== 1'b0 || ack0_cnt - a0 != 1) begin
            errors++;
            $display("FAIL p0_ack_pulse: ack=%b count=%0d required 0 and 1", p0_ack,
                     ack0_cnt - a0);
        end
    endtask

    task automatic test_round_robin();
        int s0, a0, a1, n0, n1;
        logic [23:0] exp_addr;
        do_reset();
        s0       = log_q.size();
        a0       = ack0_cnt;
        a1       = ack1_cnt;
        n0       = 0;
        n1       = 0;
        p0_addr  = 24'h000100;
        p1_addr  = 24'h000200;
        p1_we    = 1'b0;
        p1_size  = 3'd4;
        p0_req   = 1'b1;
        p1_req   = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (p0_ack) begin
                n0++;
                if (n0 == 4) p0_req = 1'b0;
            end
            if (p1_ack) begin
                n1++;
                if (n1 == 4) p1_req = 1'b0;
            end
            if (n0 == 4 && n1 == 4) break;
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick();
        checks++;
        if (log_q.size() - s0 != 8) begin
            errors++;
            $display("FAIL rr_starts: got %0d required 8", log_q.size() - s0);
        end else begin
            for (int k = 0; k < 8; k++) begin
                exp_addr = (k % 2 == 1) ? 24'h000200 : 24'h000100;
                checks++;
                if (log_q[s0 + k].addr !== exp_addr) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: addr=%h required %h", k, log_q[s0 + k].addr,
                             exp_addr);
                end
            end
        end
        checks++;
        if (ack0_cnt - a0 != 4 || ack1_cnt - a1 != 4) begin
            errors++;
            $display("FAIL rr_acks: p0=%0d p1=%0d required 4 and 4", ack0_cnt - a0,
                     ack1_cnt - a1);
        end
    endtask

    task automatic test_write();
        run_p1(1'b1, 24'h00ABCD, 32'h12345678, 3'd2);
        rec = log_q[log_q.size() - 1];
        checks++;
        if (rec.cmd !== 8'h38 || rec.rd_wr !== 1'b0 || rec.ws !== 4'd0 || rec.size !== 3'd2) begin
            errors++;
            $display("FAIL wr_fields: cmd=%h rw=%b ws=%0d size=%0d required 38 0 0 2",
                     rec.cmd, rec.rd_wr, rec.ws, rec.size);
        end
        checks++;
        if (rec.wdata !== 32'h12345678 || rec.addr !== 24'h00ABCD) begin
            errors++;
            $display("FAIL wr_data: wdata=%h addr=%h required 12345678 00ABCD", rec.wdata,
                     rec.addr);
        end
        checks++;
        if (p1_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_keeps_rdata: got %h required DEADBEEF", p1_rdata);
        end
        tick();
    endtask

    task automatic test_read_sizes();
        model_data = 32'hAABBCCDD;
        run_p1(1'b0, 24'h000010, 32'h0, 3'd1);
        checks++;
        if (p1_rdata !== 32'h000000DD || log_q[log_q.size() - 1].size !== 3'd1) begin
            errors++;
            $display("FAIL rd_size1: rdata=%h size=%0d required 000000DD 1", p1_rdata,
                     log_q[log_q.size() - 1].size);
        end
        tick();
        run_p1(1'b0, 24'h000010, 32'h0, 3'd3);
        checks++;
        if (p1_rdata !== 32'h00BBCCDD) begin
            errors++;
            $display("FAIL rd_size3: rdata=%h required 00BBCCDD", p1_rdata);
        end
        tick();
        run_p1(1'b0, 24'h000010, 32'h0, 3'd0);
        checks++;
        if (log_q[log_q.size() - 1].size !== 3'd4 || p1_rdata !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL rd_size0: size=%0d rdata=%h required 4 AABBCCDD",
                     log_q[log_q.size() - 1].size, p1_rdata);
        end
        tick();
        run_p1(1'b0, 24'h000010, 32'h0, 3'd7);
        checks++;
        if (log_q[log_q.size() - 1].size !== 3'd4) begin
            errors++;
            $display("FAIL rd_size7: size=%0d required 4", log_q[log_q.size() - 1].size);
        end
        tick();
    endtask

    task automatic test_done_hold();
        int s0, a0;
        bit got;
        done_len = 3;
        s0       = log_q.size();
        a0       = ack0_cnt;
        p0_addr  = 24'h000300;
        p0_req   = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (p0_ack) begin
                got = 1'b1;
                break;
            end
        end
        p0_req = 1'b0;
        repeat (6) tick();
        checks++;
        if (!got || ack0_cnt - a0 != 1 || log_q.size() - s0 != 1) begin
            errors++;
            $display("FAIL done_hold: acks=%0d starts=%0d required 1 and 1", ack0_cnt - a0,
                     log_q.size() - s0);
        end
        checks++;
        if (bad_start != 0) begin
            errors++;
            $display("FAIL start_during_done: got %0d required 0", bad_start);
        end
        done_len = 2;
    endtask

    task automatic test_reset_mid_wait();
        int s0, a0;
        bit got;
        s0      = log_q.size();
        a0      = ack0_cnt;
        p0_addr = 24'h000400;
        p0_req  = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (log_q.size() != s0) begin
                got = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        p0_req = 1'b0;
        repeat (10) tick();
        checks++;
        if (!got || ack0_cnt - a0 != 0) begin
            errors++;
            $display("FAIL rst_mid_wait_ack: started=%b acks=%0d required 1 and 0", got,
                     ack0_cnt - a0);
        end
        checks++;
        if (init_done !== 1'b0 || dut.state_q !== StDelay) begin
            errors++;
            $display("FAIL rst_mid_wait_state: init_done=%b state=%0d required 0 and DELAY",
                     init_done, dut.state_q);
        end
        s0 = log_q.size();
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (init_done) begin
                got = 1'b1;
                break;
            end
        end
        repeat (4) tick();
        checks++;
        if (!got || log_q.size() - s0 != QPI_STARTS || ack0_cnt - a0 != 0) begin
            errors++;
            $display("FAIL rst_recover: init=%b starts=%0d acks=%0d required 1 %0d 0", got,
                     log_q.size() - s0, ack0_cnt - a0, QPI_STARTS);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write();
        test_read_sizes();
        test_done_hold();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psram_req_arbiter.md
Name: psram_req_arbiter

Overview:
Shares one QSPI/QPI PSRAM controller between two requesters: port 0 is instruction fetch (read-only, word) and port 1 is the data bus (read/write, 1–4 bytes). The block arbitrates round-robin, converts each grant into one controller transaction (cmd, mode, wait states, start), waits for done, and returns read data with a one-cycle ack. It sits between the bus adapters and the PSRAM controller, and owns the post-reset power-up delay and the optional QPI-entry sequence.

Parameters:
INIT_DELAY, 16, clk cycles after reset before the first transaction (set to about 150 us worth in silicon)
RD_WAIT, 6, wait_states value driven for reads (controller counter units)
RD_CMD, 8'hEB, quad read command
WR_CMD, 8'h38, quad write command

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
init_done  out  1  high once the delay (and QPI entry, if enabled) has completed
p0_req  in  1  fetch request; held until p0_ack
p0_addr  in  24  fetch byte address
p0_rdata  out  32  fetch data; valid when p0_ack is high
p0_ack  out  1  one-cycle completion pulse
p1_req  in  1  data request; held until p1_ack
p1_we  in  1  1 = write, 0 = read
p1_addr  in  24  data byte address
p1_wdata  in  32  write data, right-aligned (byte 0 is sent first)
p1_size  in  3  byte count, 1..4
p1_rdata  out  32  read data, right-aligned
p1_ack  out  1  one-cycle completion pulse
mem_addr  out  24  to controller addr
mem_wdata  out  32  to controller data_i
mem_rdata  in  32  from controller data_o
mem_size  out  3  to controller size
mem_start  out  1  to controller start
mem_done  in  1  from controller done
mem_wait_states  out  4  to controller wait_states
mem_cmd  out  8  to controller cmd
mem_rd_wr  out  1  to controller rd_wr (1 = read)
mem_qspi  out  1  to controller qspi
mem_qpi  out  1  to controller qpi
mem_short_cmd  out  1  to controller short_cmd

Behaviour:
- Reset values: all outputs 0; p0_rdata and p1_rdata are 0; FSM is in DELAY; the round-robin pointer points to port 0 (port 0 wins the first tie).
- FSM states: DELAY, QPI_ENTER, IDLE, ISSUE, WAIT, RELEASE.
- DELAY: counts INIT_DELAY cycles. Exit requires the counter to have expired and mem_done = 0. Next state is QPI_ENTER if the macro is defined, otherwise IDLE.
- IDLE: grants port 0 or port 1 as described below. On the grant cycle, latches the granted addr/wdata/size/we and the port id into registers. Goes to ISSUE on the next cycle.
- Arbitration: if only one port requests, grant that port. If both request, grant the port not served last. The pointer updates on each grant.
- ISSUE: drives mem_start = 1 for exactly one cycle. All mem_* fields come from registers and stay stable until RELEASE exits. Goes to WAIT.
- WAIT: on mem_done = 1, captures mem_rdata into the granted port's rdata (reads only) and pulses that port's ack for one cycle. Goes to RELEASE.
- RELEASE: stays until mem_done = 0 (the controller holds done for about 2 cycles), then goes to IDLE. This prevents a double-count of done.
- A back-to-back grant is therefore possible on the cycle after RELEASE exits. Minimum request-to-ack latency is 3 cycles plus the controller transaction time.
- Read field mapping: mem_cmd = RD_CMD, mem_rd_wr = 1, mem_wait_states = RD_WAIT.
- Write field mapping: mem_cmd = WR_CMD, mem_rd_wr = 0, mem_wait_states = 0.
- Port 0 always uses mem_size = 4. For port 1, p1_size values 0 or greater than 4 are clamped to 4; 1..4 pass through unchanged.
- Read data: for sizes below 4, rdata bits above 8*size are zeroed.
- Mode outputs: mem_short_cmd is 0 except during QPI_ENTER. Without the macro, mem_qspi = 1 and mem_qpi = 0.
- Requests that arrive before init_done are held pending, not dropped.
- A requester that deasserts req before its ack gets undefined results. Ack is still issued if the request was already granted.
- Reset mid-transaction: returns to DELAY with no ack. The controller has its own reset, so DELAY waits for mem_done = 0 before leaving.

Optional Feature:
Macro PSRAM_ARB_QPI_INIT_EN.
- Defined: after DELAY, the FSM issues one short command in SPI mode: mem_cmd = 8'h35, mem_short_cmd = 1, mem_qspi = 0, mem_qpi = 0. It uses the same start/done/release handshake as normal transactions. After that, all transactions use mem_qpi = 1 and mem_qspi = 0. init_done rises on exit from QPI_ENTER.
- Not defined: the QPI_ENTER state is absent, init_done rises on exit from DELAY, and transactions use QSPI mode.

Decomposition:
- Shared package psram_pkg holds:
  - the state encoding enum;
  - the command constants (8'hEB, 8'h38, 8'h35);
  - the port-id constants P_FETCH = 0 and P_DATA = 1;
  - a txn_t struct {addr, wdata, size, we}.
- One sub-module, psram_rr_arb2: a 2-way round-robin with a grant-enable input and a registered last-grant pointer.
- The FSM and field mapping stay in the top.

Test Plan:
- Reset, then hold p0_req with addr 0x000100 → no mem_start before INIT_DELAY cycles; then one start with cmd 0xEB, rd_wr = 1, wait 6, size 4. With a controller model returning 0xDEADBEEF, p0_rdata = 0xDEADBEEF and p0_ack is a single pulse.
- Assert p0_req and p1_req together for 4 transactions each → grants alternate 0,1,0,1,…, starting with port 0; exactly 8 starts and 8 acks.
- p1 write, size 2, wdata 0x12345678, addr 0x00ABCD → cmd 0x38, rd_wr = 0, wait 0, size 2, mem_wdata passed unchanged.
- p1 read, size 1, model data 0xAABBCCDD → p1_rdata = 0x000000DD. Also check that p1_size = 0 and p1_size = 7 both drive mem_size = 4.
- Model holds done high for 3 cycles → exactly one ack and no new start until done falls. Asserting rst mid-WAIT → no ack and the FSM is back in DELAY.
- With PSRAM_ARB_QPI_INIT_EN defined: the first start carries cmd 0x35 with short_cmd = 1, qpi = 0. init_done rises after its done. Subsequent transactions have qpi = 1.
